vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates VGA raster timing: pixel clock-enable, horizontal/vertical counters,
//  sync pulses and blanking. Drives DrawX/DrawY into color_mapper and hs/vs/blank
//  to the DAC/VGA pins. Provides a once-per-frame tick for game/sprite position
//  updates, so positions change only during vertical blanking.
// PARAMETERS
//  CLK_DIV     2    Clk cycles per pixel (50 MHz Clk -> 25 MHz pixel); >=1
//  H_VISIBLE   640  visible pixels per line
//  H_FRONT     16   horizontal front porch, pixels
//  H_SYNC      96   horizontal sync width, pixels
//  H_BACK      48   horizontal back porch, pixels
//  V_VISIBLE   480  visible lines per frame
//  V_FRONT     10   vertical front porch, lines
//  V_SYNC      2    vertical sync width, lines
//  V_BACK      33   vertical back porch, lines
// PORTS
//  Clk         in   1   system clock; all state on rising edge
//  Reset       in   1   asynchronous, active-high
//  pixel_ce    out  1   one-Clk-wide pulse every CLK_DIV Clk cycles
//  DrawX       out  10  current pixel column, 0..H_TOTAL-1
//  DrawY       out  10  current pixel row, 0..V_TOTAL-1
//  hs          out  1   horizontal sync, active-low
//  vs          out  1   vertical sync, active-low
//  blank       out  1   1 = visible region, 0 = blanking
//  sync        out  1   tied 0 (composite sync unused)
//  frame_tick  out  1   one-Clk pulse at start of vertical blanking
// BEHAVIOUR
//  - H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525); both <= 1024.
//    Elaboration error otherwise.
//  - Reset (async): divider=0, DrawX=0, DrawY=0, hs=1, vs=1, blank=1, pixel_ce=0,
//    frame_tick=0. First pixel_ce pulse is CLK_DIV Clk cycles after Reset falls.
//  - Divider counts 0..CLK_DIV-1. pixel_ce is registered and high while divider
//    wraps. CLK_DIV=1: pixel_ce constantly 1 after reset.
//  - On each Clk with pixel_ce=1:
//    - DrawX increments. At DrawX=H_TOTAL-1 it wraps to 0 and DrawY increments.
//    - At DrawY=V_TOTAL-1 together with the DrawX wrap, DrawY wraps to 0.
//    - DrawX/DrawY hold while pixel_ce=0.
//  - hs, vs, blank are registered, decoded from the next counter values, and change
//    in the same Clk cycle as DrawX/DrawY (zero skew):
//    - hs=0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751)
//    - vs=0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491)
//    - blank=1 iff DrawX < H_VISIBLE && DrawY < V_VISIBLE
//  - frame_tick=1 for exactly the one Clk cycle in which (DrawX,DrawY) first becomes
//    (0,V_VISIBLE). Exactly one pulse per frame.
//  - Counter arithmetic is 10-bit unsigned. Compare against wrap limits, never rely
//    on natural overflow.
//  - Reset mid-frame returns every output to its reset value immediately. There is
//    no partial frame_tick.
// STRUCTURE
//  - vga_timing_pkg: typedef logic [9:0] coord_t; default timing localparams;
//    function computing H_TOTAL/V_TOTAL. Shared with color_mapper.
//  - Sub-module pixel_ce_div (parameter CLK_DIV): divider counter plus registered
//    pixel_ce. The top holds the counters and decode registers.
// TESTING
//  1. Reset held 5 Clk, released -> outputs at reset values.
//     First pixel_ce at Clk 2 after release; DrawX=1 on that edge.
//  2. Run one line -> hs low for exactly 96 pixel_ce (192 Clk), starting at DrawX=656.
//     Line period 1600 Clk.
//  3. Run two frames -> frame period 840000 Clk. vs low for 2 lines (3200 Clk) at
//     DrawY=490. frame_tick count=1 per frame, at (0,480).
//  4. blank sweep -> blank=1 count per frame = 307200 pixels. blank=0 whenever
//     DrawX>=640 or DrawY>=480.
//  5. Assert Reset at (DrawX=700, DrawY=300) mid-pulse -> hs=1, DrawX=DrawY=0 without
//     waiting for Clk. Clean restart matches scenario 1.
//  6. CLK_DIV=1, H/V params 8/2/2/2, 6/1/1/1 -> pixel_ce always 1. Line=14 Clk,
//     frame=126 Clk. hs low at DrawX=10..11.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster types and default 640x480@60 timing, also used by color_mapper.
package vga_timing_pkg;
  typedef logic [9:0] coord_t;

  localparam int unsigned DEF_CLK_DIV   = 2;
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  function automatic int unsigned timing_total(input int unsigned visible, front, sync_w, back);
    return visible + front + sync_w + back;
  endfunction
endpackage

// File: rtl/pixel_ce_div.sv
// Clock divider: wrap is the combinational last-cycle flag, pixel_ce its registered copy.
module pixel_ce_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic wrap,
  output logic pixel_ce
);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("pixel_ce_div: CLK_DIV must be >= 1");
  end

  logic [DW-1:0] div;

  assign wrap = (div == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= '0;
      pixel_ce <= 1'b0;
    end else begin
      div      <= wrap ? '0 : div + DW'(1);
      pixel_ce <= wrap;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters plus sync/blank/frame_tick registered from the
// next counter values so every output changes on the same Clk edge.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   pixel_ce,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   hs,
  output logic   vs,
  output logic   blank,
  output logic   sync,
  output logic   frame_tick
);
  localparam int unsigned H_TOTAL = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t V_TICK = coord_t'(V_VISIBLE);
  // Sync bounds kept as int so an end bound of 1024 cannot alias to 0.
  localparam int HS_START = int'(H_VISIBLE + H_FRONT);
  localparam int HS_END   = int'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam int VS_START = int'(V_VISIBLE + V_FRONT);
  localparam int VS_END   = int'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam int H_VIS_I  = int'(H_VISIBLE);
  localparam int V_VIS_I  = int'(V_VISIBLE);

  logic   wrap;
  coord_t next_x, next_y;

  pixel_ce_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk      (Clk),
    .rst      (Reset),
    .wrap     (wrap),
    .pixel_ce (pixel_ce)
  );

  always_comb begin
    next_x = DrawX;
    next_y = DrawY;
    if (wrap) begin
      if (DrawX == H_LAST) begin
        next_x = '0;
        next_y = (DrawY == V_LAST) ? '0 : DrawY + coord_t'(1);
      end else begin
        next_x = DrawX + coord_t'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DrawX      <= '0;
      DrawY      <= '0;
      hs         <= 1'b1;
      vs         <= 1'b1;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      DrawX      <= next_x;
      DrawY      <= next_y;
      hs         <= !(int'(next_x) >= HS_START && int'(next_x) < HS_END);
      vs         <= !(int'(next_y) >= VS_START && int'(next_y) < VS_END);
      blank      <= (int'(next_x) < H_VIS_I) && (int'(next_y) < V_VIS_I);
      // Only a pixel advance can land on (0,V_VISIBLE), so this fires once per frame.
      frame_tick <= wrap && (next_x == '0) && (next_y == V_TICK);
    end
  end

  assign sync = 1'b0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench: a driver pushes reference-model expectations, a monitor
// pops and compares them against two differently parameterized instances.
module tb_vga_timing_gen;
  logic       Clk, Reset;
  logic       pce_a, hs_a, vs_a, blank_a, sync_a, ft_a;
  logic [9:0] x_a, y_a;
  logic       pce_b, hs_b, vs_b, blank_b, sync_b, ft_b;
  logic [9:0] x_b, y_b;

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_a (
    .Clk(Clk), .Reset(Reset), .pixel_ce(pce_a), .DrawX(x_a), .DrawY(y_a),
    .hs(hs_a), .vs(vs_a), .blank(blank_a), .sync(sync_a), .frame_tick(ft_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .pixel_ce(pce_b), .DrawX(x_b), .DrawY(y_b),
    .hs(hs_b), .vs(vs_b), .blank(blank_b), .sync(sync_b), .frame_tick(ft_b)
  );

  typedef struct {
    bit pce; int x; int y; bit hs; bit vs; bit blank; bit ft;
  } vexp_t;
  typedef struct { vexp_t a; vexp_t b; } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  bit   done   = 0;
  int   ft_seen = 0;
  int   ft_expected = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Raster position as a pure function of Clk edges elapsed since reset release.
  function automatic vexp_t model(input int n, input int cd,
                                  input int hv, input int hf, input int hsw, input int hb,
                                  input int vv, input int vf, input int vsw, input int vb);
    vexp_t e;
    int ht, vt, p;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p  = n / cd;
    e.x     = p % ht;
    e.y     = (p / ht) % vt;
    e.pce   = (n > 0) && (n % cd == 0);
    e.hs    = !(e.x >= hv + hf && e.x < hv + hf + hsw);
    e.vs    = !(e.y >= vv + vf && e.y < vv + vf + vsw);
    e.blank = (e.x < hv) && (e.y < vv);
    e.ft    = e.pce && e.x == 0 && e.y == vv;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
  endtask

  task automatic compare_all(input exp_t e);
    check("a.pixel_ce", int'(pce_a), int'(e.a.pce));
    check("a.DrawX",    int'(x_a),   e.a.x);
    check("a.DrawY",    int'(y_a),   e.a.y);
    check("a.hs",       int'(hs_a),  int'(e.a.hs));
    check("a.vs",       int'(vs_a),  int'(e.a.vs));
    check("a.blank",    int'(blank_a), int'(e.a.blank));
    check("a.frame_tick", int'(ft_a), int'(e.a.ft));
    check("a.sync",     int'(sync_a), 0);
    check("b.pixel_ce", int'(pce_b), int'(e.b.pce));
    check("b.DrawX",    int'(x_b),   e.b.x);
    check("b.DrawY",    int'(y_b),   e.b.y);
    check("b.hs",       int'(hs_b),  int'(e.b.hs));
    check("b.vs",       int'(vs_b),  int'(e.b.vs));
    check("b.blank",    int'(blank_b), int'(e.b.blank));
    check("b.frame_tick", int'(ft_b), int'(e.b.ft));
    check("b.sync",     int'(sync_b), 0);
  endtask

  task automatic driver();
    int   n = 0;
    int   hold = 4;
    exp_t e;
    for (int cyc = 0; cyc < 7000; cyc++) begin
      @(posedge Clk);
      if (!Reset) n++;
      else n = 0;
      #2;
      if (Reset) begin
        if (hold > 0) hold--;
        else Reset = 1'b0;
      end else if (cyc == 3000 || (cyc > 100 && $urandom_range(0, 1999) == 0)) begin
        // Asserted mid-cycle: the next monitor sample precedes any Clk edge.
        Reset = 1'b1;
        n = 0;
        hold = $urandom_range(0, 4);
      end
      e.a = model(n, 2, 20, 3, 5, 4, 10, 2, 2, 3);
      e.b = model(n, 1, 8, 2, 2, 2, 6, 1, 1, 1);
      ft_expected += int'(e.a.ft);
      q.push_back(e);
    end
    done = 1;
  endtask

  task automatic monitor();
    exp_t e;
    int   idle = 0;
    while (!(done && q.size() == 0)) begin
      @(negedge Clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        ft_seen += int'(ft_a);
        compare_all(e);
        idle = 0;
      end else if (++idle > 20) begin
        check("monitor_starved", idle, 0);
        break;
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    #1;
    check("reset.DrawX", int'(x_a), 0);
    check("reset.hs", int'(hs_a), 1);
    check("reset.blank", int'(blank_a), 1);
    fork
      driver();
      monitor();
    join
    check("frame_tick_count", ft_seen, ft_expected);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
